slurm16_cpu_register_file: RTL and testbench
============================================

Name: slurm16_cpu_register_file

Overview:
- Register file stage directly downstream of the SLURM16 instruction decoder.
- Consumes the decoder's regA_sel/regB_sel and returns the two operands one cycle later for the execute stage.
- Accepts one writeback per cycle.
- After reset, an internal sequencer clears the whole array so that no register holds X.

Parameters:
- BITS, 16, data width of each register.
- REGISTER_BITS, 7, width of register select fields.
- NUM_REGS, 128, number of registers; must equal 2**REGISTER_BITS.

Ports:
- CLK  input  1  system clock; all logic is rising-edge.
- RST  input  1  synchronous, active-high reset.
- regA_sel  input  REGISTER_BITS  read port A address, from the decoder.
- regB_sel  input  REGISTER_BITS  read port B address, from the decoder.
- hold  input  1  pipeline stall; when 1, the read outputs keep their captured addresses.
- regWr_sel  input  REGISTER_BITS  writeback address.
- regWr_data  input  BITS  writeback data.
- regWr_en  input  1  writeback strobe.
- regARead_data  output  BITS  operand A, registered.
- regBRead_data  output  BITS  operand B, registered.
- init_busy  output  1  high while the clear sequence runs.

Behaviour:
- One clock, one synchronous active-high reset (RST). No asynchronous logic.

Reset:
- Sampled RST=1 sets regARead_data=0, regBRead_data=0 and init_busy=1.
- It loads the clear counter with 0 and enters state INIT.
- RST asserted mid-INIT restarts the counter at 0.

FSM states:
- INIT:
  - Each cycle writes 0 to array[counter], then counter+1.
  - On the cycle that writes counter==NUM_REGS-1, the next state is RUN and init_busy drops to 0 on that same edge.
  - INIT therefore lasts exactly NUM_REGS cycles after reset deasserts.
- RUN: normal operation. There is no return to INIT except via RST.

Behaviour during INIT:
- regWr_en is ignored and writes are dropped.
- Read outputs are forced to 0.
- hold has no effect.

Reads (RUN):
- Latency is 1 cycle. At edge N the block captures the sel values and loads array[sel] into the output register, valid after edge N.
- Address 0 always reads 0, regardless of array contents.
- hold=1: the latched read addresses are kept and the sel inputs are ignored. Outputs re-read the latched addresses each cycle, so they track writes made during the stall (see bypass).

Writes (RUN):
- With regWr_en=1, array[regWr_sel] <= regWr_data at the edge.
- A write to address 0 is discarded.
- A write and a read of different addresses in the same cycle are independent.

Same address, same cycle (read addr == regWr_sel, regWr_en=1, addr≠0):
- Governed by the optional feature below.
- The rule applies identically to port A, port B, and both ports at once.

Width:
- No arithmetic on data.
- The counter is REGISTER_BITS+1 wide so that termination is not aliased by wrap-around.

Optional Feature:
- Macro: SLURM16_REGFILE_BYPASS_EN.
- Defined: a same-cycle write to the address being read is forwarded, so the output register loads regWr_data (write-first). This also holds while hold=1 for the latched address.
- Undefined: read-first. The output loads the pre-write array value, and the new value appears on the next read. Under hold=1 the new value appears one cycle after the write.
- r0 reads 0 in both builds.

Test Plan:
- Reset clear:
  - Stimulus: assert RST 2 cycles, release.
  - Response: init_busy=1 for exactly 128 cycles, then 0.
  - Then read every address 0..127 on both ports; all return 0x0000.
- Write/read:
  - Stimulus: write r5=0xBEEF, r127=0x1234; next cycle regA_sel=5, regB_sel=127.
  - Response: after 1 edge A=0xBEEF, B=0x1234.
  - Write r0=0xFFFF, then read r0: returns 0x0000.
- Collision:
  - Stimulus: r9=0x1111; in one cycle write r9=0x2222 and read r9 on A and B.
  - Response: A=B=0x2222 with BYPASS_EN, 0x1111 without; next read gives 0x2222 in both builds.
- Hold:
  - Stimulus: read r3 (=0x0003) on A, assert hold, change regA_sel to 4, write r3=0x0AAA.
  - Response: A stays addressed to r3 and shows 0x0AAA (bypass build: same cycle as the write; non-bypass: one cycle later). A never shows r4.
- Reset mid-init:
  - Stimulus: during INIT at counter=60, issue regWr_en to r70=0x5555, then pulse RST.
  - Response: the write is dropped, init_busy stays high for a full 128 cycles after release, and r70 reads 0.

Source files
------------

// File: rtl/slurm16_cpu_register_file.sv
// SLURM16 register file: two registered read ports and one write port. After reset an
// internal sequencer clears every register. Optional macro SLURM16_REGFILE_BYPASS_EN.
module slurm16_cpu_register_file #(
    parameter int unsigned BITS          = 16,
    parameter int unsigned REGISTER_BITS = 7,
    parameter int unsigned NUM_REGS      = 128
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [REGISTER_BITS-1:0] regA_sel,
    input  logic [REGISTER_BITS-1:0] regB_sel,
    input  logic                     hold,
    input  logic [REGISTER_BITS-1:0] regWr_sel,
    input  logic [BITS-1:0]          regWr_data,
    input  logic                     regWr_en,
    output logic [BITS-1:0]          regARead_data,
    output logic [BITS-1:0]          regBRead_data,
    output logic                     init_busy
);

    localparam int unsigned CntW = REGISTER_BITS + 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(NUM_REGS - 1);

`ifdef SLURM16_REGFILE_BYPASS_EN
    localparam bit Bypass = 1'b1;
`else
    localparam bit Bypass = 1'b0;
`endif

    typedef enum logic [0:0] {StInit, StRun} state_e;

    state_e                   state_q, state_d;
    logic [CntW-1:0]          cnt_q, cnt_d;
    logic [REGISTER_BITS-1:0] lat_a_q, lat_a_d, lat_b_q, lat_b_d;
    logic [BITS-1:0]          rd_a_q, rd_a_d, rd_b_q, rd_b_d;
    logic [BITS-1:0]          mem_q [NUM_REGS];

    logic                     mem_we;
    logic [REGISTER_BITS-1:0] mem_waddr;
    logic [BITS-1:0]          mem_wdata;
    logic [REGISTER_BITS-1:0] addr_a, addr_b;
    logic                     fwd_a, fwd_b;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lat_a_d   = lat_a_q;
        lat_b_d   = lat_b_q;
        rd_a_d    = '0;
        rd_b_d    = '0;
        mem_we    = 1'b0;
        mem_waddr = regWr_sel;
        mem_wdata = regWr_data;
        addr_a    = hold ? lat_a_q : regA_sel;
        addr_b    = hold ? lat_b_q : regB_sel;
        fwd_a     = regWr_en && (regWr_sel == addr_a);
        fwd_b     = regWr_en && (regWr_sel == addr_b);

        unique case (state_q)
            StInit: begin
                // Clear sequencer owns the write port; reads stay at zero.
                mem_we    = 1'b1;
                mem_waddr = cnt_q[REGISTER_BITS-1:0];
                mem_wdata = '0;
                cnt_d     = cnt_q + CntW'(1);
                lat_a_d   = regA_sel;
                lat_b_d   = regB_sel;
                if (cnt_q == LastCnt) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                mem_we  = regWr_en && (regWr_sel != '0);
                lat_a_d = addr_a;
                lat_b_d = addr_b;
                if (addr_a != '0) begin
                    rd_a_d = (Bypass && fwd_a) ? regWr_data : mem_q[addr_a];
                end
                if (addr_b != '0) begin
                    rd_b_d = (Bypass && fwd_b) ? regWr_data : mem_q[addr_b];
                end
            end
            default: begin
                state_d = StInit;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StInit;
            cnt_q   <= '0;
            lat_a_q <= '0;
            lat_b_q <= '0;
            rd_a_q  <= '0;
            rd_b_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lat_a_q <= lat_a_d;
            lat_b_q <= lat_b_d;
            rd_a_q  <= rd_a_d;
            rd_b_q  <= rd_b_d;
        end
    end

    // Storage has no reset; the clear sequencer initialises it.
    always_ff @(posedge CLK) begin
        if (!RST && mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign regARead_data = rd_a_q;
    assign regBRead_data = rd_b_q;
    assign init_busy     = (state_q == StInit);

endmodule

// File: tb/tb_slurm16_cpu_register_file.sv
// Randomised and directed bench for slurm16_cpu_register_file against a behavioural model.
module tb_slurm16_cpu_register_file;

    localparam int BITS = 16;
    localparam int RB   = 7;
    localparam int NREG = 128;

`ifdef SLURM16_REGFILE_BYPASS_EN
    localparam bit Byp = 1'b1;
`else
    localparam bit Byp = 1'b0;
`endif

    logic            CLK = 1'b0;
    logic            RST;
    logic [RB-1:0]   regA_sel, regB_sel, regWr_sel;
    logic            hold, regWr_en;
    logic [BITS-1:0] regWr_data;
    logic [BITS-1:0] regARead_data, regBRead_data;
    logic            init_busy;

    int vecs = 0;
    int errs = 0;

    logic [BITS-1:0] ref_mem [NREG];
    int              ref_lat_a, ref_lat_b;
    logic [BITS-1:0] exp_a, exp_b;

    slurm16_cpu_register_file #(
        .BITS(BITS), .REGISTER_BITS(RB), .NUM_REGS(NREG)
    ) dut (
        .CLK(CLK), .RST(RST), .regA_sel(regA_sel), .regB_sel(regB_sel), .hold(hold),
        .regWr_sel(regWr_sel), .regWr_data(regWr_data), .regWr_en(regWr_en),
        .regARead_data(regARead_data), .regBRead_data(regBRead_data), .init_busy(init_busy)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // One RUN-mode cycle: predict outputs from the model, apply the edge, update the model.
    task automatic cycle();
        int a, b;
        a = hold ? ref_lat_a : int'(regA_sel);
        b = hold ? ref_lat_b : int'(regB_sel);
        exp_a = (a == 0) ? 16'h0 :
                (Byp && regWr_en && int'(regWr_sel) == a) ? regWr_data : ref_mem[a];
        exp_b = (b == 0) ? 16'h0 :
                (Byp && regWr_en && int'(regWr_sel) == b) ? regWr_data : ref_mem[b];
        if (regWr_en && regWr_sel != 0) ref_mem[regWr_sel] = regWr_data;
        ref_lat_a = a;
        ref_lat_b = b;
        step();
    endtask

    task automatic idle_inputs();
        hold = 1'b0; regWr_en = 1'b0; regWr_sel = '0; regWr_data = '0;
        regA_sel = '0; regB_sel = '0;
    endtask

    task automatic test_reset();
        int n;
        idle_inputs();
        RST = 1'b1;
        step();
        step();
        vecs++;
        if (init_busy !== 1'b1 || regARead_data !== 16'h0 || regBRead_data !== 16'h0) begin
            $display("FAIL reset_state: busy=%b A=%h B=%h required busy=1 A=0000 B=0000",
                     init_busy, regARead_data, regBRead_data);
            errs++;
        end
        RST = 1'b0;
        regA_sel = 7'd5; regB_sel = 7'd9;
        n = 0;
        do begin
            if (n == 100) begin
                regWr_en = 1'b1; regWr_sel = 7'd5; regWr_data = 16'h5555;
            end else begin
                regWr_en = 1'b0;
            end
            step();
            n++;
            if (n == 50) begin
                vecs++;
                if (regARead_data !== 16'h0 || regBRead_data !== 16'h0) begin
                    $display("FAIL init_reads_zero: A=%h B=%h required 0000", regARead_data,
                             regBRead_data);
                    errs++;
                end
            end
        end while (init_busy && n < 300);
        regWr_en = 1'b0;
        vecs++;
        if (n != NREG) begin
            $display("FAIL init_length: busy cycles=%0d required %0d", n, NREG);
            errs++;
        end
        for (int i = 0; i < NREG; i++) ref_mem[i] = '0;
        ref_lat_a = 0; ref_lat_b = 0;
        for (int i = 0; i < NREG; i++) begin
            regA_sel = RB'(i);
            regB_sel = RB'(NREG - 1 - i);
            cycle();
            vecs++;
            if (regARead_data !== 16'h0 || regBRead_data !== 16'h0) begin
                $display("FAIL clear_read r%0d/r%0d: A=%h B=%h required 0000", i,
                         NREG - 1 - i, regARead_data, regBRead_data);
                errs++;
            end
        end
    endtask

    task automatic test_write_read();
        regWr_en = 1'b1; regWr_sel = 7'd5; regWr_data = 16'hBEEF;
        cycle();
        regWr_sel = 7'd127; regWr_data = 16'h1234;
        cycle();
        regWr_en = 1'b0;
        regA_sel = 7'd5; regB_sel = 7'd127;
        cycle();
        vecs++;
        if (regARead_data !== 16'hBEEF || regBRead_data !== 16'h1234) begin
            $display("FAIL write_read: A=%h B=%h required BEEF 1234", regARead_data,
                     regBRead_data);
            errs++;
        end
        regWr_en = 1'b1; regWr_sel = 7'd0; regWr_data = 16'hFFFF;
        cycle();
        regWr_en = 1'b0; regA_sel = 7'd0; regB_sel = 7'd0;
        cycle();
        vecs++;
        if (regARead_data !== 16'h0 || regBRead_data !== 16'h0) begin
            $display("FAIL r0_zero: A=%h B=%h required 0000", regARead_data, regBRead_data);
            errs++;
        end
    endtask

    task automatic test_collision();
        logic [BITS-1:0] want;
        regWr_en = 1'b1; regWr_sel = 7'd9; regWr_data = 16'h1111;
        cycle();
        regWr_data = 16'h2222; regA_sel = 7'd9; regB_sel = 7'd9;
        cycle();
        want = Byp ? 16'h2222 : 16'h1111;
        vecs++;
        if (regARead_data !== want || regBRead_data !== want) begin
            $display("FAIL collision: A=%h B=%h required %h", regARead_data, regBRead_data,
                     want);
            errs++;
        end
        regWr_en = 1'b0;
        cycle();
        vecs++;
        if (regARead_data !== 16'h2222 || regBRead_data !== 16'h2222) begin
            $display("FAIL collision_after: A=%h B=%h required 2222", regARead_data,
                     regBRead_data);
            errs++;
        end
    endtask

    task automatic test_hold();
        logic [BITS-1:0] want;
        regWr_en = 1'b1; regWr_sel = 7'd3; regWr_data = 16'h0003;
        cycle();
        regWr_sel = 7'd4; regWr_data = 16'h4444;
        cycle();
        regWr_en = 1'b0; regA_sel = 7'd3; regB_sel = 7'd0;
        cycle();
        vecs++;
        if (regARead_data !== 16'h0003) begin
            $display("FAIL hold_pre: A=%h required 0003", regARead_data);
            errs++;
        end
        hold = 1'b1; regA_sel = 7'd4;
        regWr_en = 1'b1; regWr_sel = 7'd3; regWr_data = 16'h0AAA;
        cycle();
        want = Byp ? 16'h0AAA : 16'h0003;
        vecs++;
        if (regARead_data !== want) begin
            $display("FAIL hold_write: A=%h required %h", regARead_data, want);
            errs++;
        end
        regWr_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cycle();
            vecs++;
            if (regARead_data !== 16'h0AAA) begin
                $display("FAIL hold_track%0d: A=%h required 0AAA", i, regARead_data);
                errs++;
            end
        end
        hold = 1'b0;
        cycle();
        vecs++;
        if (regARead_data !== 16'h4444) begin
            $display("FAIL hold_release: A=%h required 4444", regARead_data);
            errs++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            // Narrow address range to make collisions and r0 hits frequent.
            regA_sel   = RB'($urandom_range(0, 11));
            regB_sel   = RB'($urandom_range(0, 11));
            regWr_sel  = ($urandom_range(0, 3) == 0) ? RB'($urandom) : RB'($urandom_range(0, 11));
            regWr_data = BITS'($urandom);
            regWr_en   = ($urandom_range(0, 1) == 1);
            hold       = ($urandom_range(0, 3) == 0);
            cycle();
            vecs++;
            if (regARead_data !== exp_a || regBRead_data !== exp_b) begin
                $display("FAIL random[%0d]: A=%h B=%h required %h %h", i, regARead_data,
                         regBRead_data, exp_a, exp_b);
                errs++;
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_init();
        int n;
        idle_inputs();
        RST = 1'b1;
        step();
        RST = 1'b0;
        for (int i = 0; i < 60; i++) step();
        regWr_en = 1'b1; regWr_sel = 7'd70; regWr_data = 16'h5555;
        step();
        regWr_en = 1'b0;
        RST = 1'b1;
        step();
        RST = 1'b0;
        regA_sel = 7'd70; regB_sel = 7'd70;
        n = 0;
        do begin
            step();
            n++;
        end while (init_busy && n < 300);
        vecs++;
        if (n != NREG) begin
            $display("FAIL mid_init_length: busy cycles=%0d required %0d", n, NREG);
            errs++;
        end
        for (int i = 0; i < NREG; i++) ref_mem[i] = '0;
        ref_lat_a = 70; ref_lat_b = 70;
        cycle();
        vecs++;
        if (regARead_data !== 16'h0 || regBRead_data !== 16'h0) begin
            $display("FAIL mid_init_r70: A=%h B=%h required 0000", regARead_data,
                     regBRead_data);
            errs++;
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_collision();
        test_hold();
        test_random();
        test_reset_mid_init();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
